// File: rtl/ycbcr2rgb_stream_ctrl.sv
// Credit-based sequencer around a fixed-latency YCbCr555->RGB converter, with SOF/EOL sideband and an FWFT output FIFO.
// Optional line-length checker is built when LINE_CHECK_EN is defined.
module ycbcr2rgb_stream_ctrl #(
    parameter int unsigned CONV_LAT   = 2,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned H_ACTIVE   = 640
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [14:0] s_data,
    input  logic        s_sof,
    input  logic        s_eol,
    output logic [14:0] conv_ycbcr,
    input  logic [23:0] conv_rgb,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [23:0] m_data,
    output logic        m_sof,
    output logic        m_eol,
    output logic        busy,
    output logic        err_line,
    output logic [15:0] err_count
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(FIFO_DEPTH + CONV_LAT + 1);

    if (CONV_LAT < 1 || FIFO_DEPTH < CONV_LAT + 1 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || H_ACTIVE < 1)
    begin : g_bad_cfg
        $error("ycbcr2rgb_stream_ctrl: illegal parameter set");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_SYNC,
        S_RUN,
        S_DRAIN
    } state_t;

    state_t              state_q, state_d;
    logic [14:0]         conv_ycbcr_q, conv_ycbcr_d;
    logic [CONV_LAT-1:0] sr_vld_q, sr_vld_d;
    logic [CONV_LAT-1:0] sr_sof_q, sr_sof_d;
    logic [CONV_LAT-1:0] sr_eol_q, sr_eol_d;
    logic [25:0]         mem_q [FIFO_DEPTH];
    logic [25:0]         mem_d [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]       fifo_cnt_q, fifo_cnt_d;
    logic [CW-1:0]       inflight;
    logic                busy_q, busy_d;
    logic                credit_ok;
    logic                take;
    logic                push;
    logic                pop;
    logic [25:0]         head;

    always_comb begin
        inflight = '0;
        for (int unsigned i = 0; i < CONV_LAT; i++) begin
            inflight = inflight + CW'(sr_vld_q[i]);
        end
    end

    // Converter cannot stall: only accept what the FIFO is guaranteed to hold.
    assign credit_ok = (fifo_cnt_q + inflight) < CW'(FIFO_DEPTH);
    assign s_ready   = (state_q == S_SYNC) | ((state_q == S_RUN) & credit_ok);
    assign take      = s_valid & s_ready & ((state_q == S_RUN) | s_sof);
    assign push      = sr_vld_q[CONV_LAT-1];
    assign m_valid   = (fifo_cnt_q != '0);
    assign pop       = m_valid & m_ready;
    assign head      = mem_q[rd_ptr_q];

    assign m_data     = {head[23:16], head[7:0], head[15:8]};
    assign m_sof      = m_valid & head[25];
    assign m_eol      = m_valid & head[24];
    assign conv_ycbcr = conv_ycbcr_q;
    assign busy       = busy_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (enable) state_d = S_SYNC;
            S_SYNC: begin
                if (take)         state_d = enable ? S_RUN : S_DRAIN;
                else if (!enable) state_d = S_IDLE;
            end
            S_RUN:   if (!enable) state_d = S_DRAIN;
            S_DRAIN: if (inflight == '0 && fifo_cnt_q == '0) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);

        conv_ycbcr_d = take ? s_data : conv_ycbcr_q;

        sr_vld_d[0] = take;
        sr_sof_d[0] = s_sof;
        sr_eol_d[0] = s_eol;
        for (int unsigned i = 1; i < CONV_LAT; i++) begin
            sr_vld_d[i] = sr_vld_q[i-1];
            sr_sof_d[i] = sr_sof_q[i-1];
            sr_eol_d[i] = sr_eol_q[i-1];
        end

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = {sr_sof_q[CONV_LAT-1], sr_eol_q[CONV_LAT-1], conv_rgb};
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        fifo_cnt_d = fifo_cnt_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            busy_q       <= 1'b0;
            conv_ycbcr_q <= '0;
            sr_vld_q     <= '0;
            sr_sof_q     <= '0;
            sr_eol_q     <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fifo_cnt_q   <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            busy_q       <= busy_d;
            conv_ycbcr_q <= conv_ycbcr_d;
            sr_vld_q     <= sr_vld_d;
            sr_sof_q     <= sr_sof_d;
            sr_eol_q     <= sr_eol_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fifo_cnt_q   <= fifo_cnt_d;
            mem_q        <= mem_d;
        end
    end

`ifdef LINE_CHECK_EN
    logic [15:0] x_q, x_d;
    logic [15:0] x_cur;
    logic        err_line_q, err_line_d;
    logic [15:0] err_count_q, err_count_d;
    logic        line_err;

    // A beat arriving at index H_ACTIVE is the overrun; it restarts the line without a second EOL check.
    always_comb begin
        x_d         = x_q;
        x_cur       = s_sof ? '0 : x_q;
        line_err    = 1'b0;
        err_line_d  = 1'b0;
        err_count_d = err_count_q;
        if (take) begin
            if (x_cur == 16'(H_ACTIVE)) begin
                line_err = 1'b1;
                x_d      = '0;
            end else if (s_eol) begin
                line_err = (x_cur != 16'(H_ACTIVE - 1));
                x_d      = '0;
            end else begin
                x_d = x_cur + 16'd1;
            end
        end
        if (line_err) begin
            err_line_d = 1'b1;
            if (err_count_q != '1) err_count_d = err_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q         <= '0;
            err_line_q  <= 1'b0;
            err_count_q <= '0;
        end else begin
            x_q         <= x_d;
            err_line_q  <= err_line_d;
            err_count_q <= err_count_d;
        end
    end

    assign err_line  = err_line_q;
    assign err_count = err_count_q;
`else
    assign err_line  = 1'b0;
    assign err_count = '0;
`endif

endmodule

// File: tb/tb_ycbcr2rgb_stream_ctrl.sv
// Directed bench for ycbcr2rgb_stream_ctrl: latency, SYNC discard, backpressure, drain, reset abort, line check.
`timescale 1ns/1ps
module tb_ycbcr2rgb_stream_ctrl;
    localparam int unsigned CONV_LAT   = 2;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned H_ACTIVE   = 8;
`ifdef LINE_CHECK_EN
    localparam int unsigned ERR_MID = 1;
    localparam int unsigned ERR_END = 2;
`else
    localparam int unsigned ERR_MID = 0;
    localparam int unsigned ERR_END = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [14:0] s_data = '0;
    logic        s_sof = 1'b0;
    logic        s_eol = 1'b0;
    logic [14:0] conv_ycbcr;
    logic [23:0] conv_rgb;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [23:0] m_data;
    logic        m_sof;
    logic        m_eol;
    logic        busy;
    logic        err_line;
    logic [15:0] err_count;

    int unsigned n_tests = 0;
    int unsigned n_fail = 0;
    int unsigned out_n = 0;
    int unsigned err_pulses = 0;
    logic [25:0] exp_q [$];

    always #5 clk = ~clk;

    ycbcr2rgb_stream_ctrl #(
        .CONV_LAT  (CONV_LAT),
        .FIFO_DEPTH(FIFO_DEPTH),
        .H_ACTIVE  (H_ACTIVE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_sof     (s_sof),
        .s_eol     (s_eol),
        .conv_ycbcr(conv_ycbcr),
        .conv_rgb  (conv_rgb),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_sof     (m_sof),
        .m_eol     (m_eol),
        .busy      (busy),
        .err_line  (err_line),
        .err_count (err_count)
    );

    function automatic logic [7:0] clamp8(input int v);
        if (v < 0) return 8'd0;
        if (v > 255) return 8'd255;
        return v[7:0];
    endfunction

    // Returns {R,G,B}
    function automatic logic [23:0] cvt_rgb(input logic [14:0] p);
        int y, cb, cr;
        y  = int'({p[4:0], 3'b000});
        cb = int'({p[9:5], 3'b000}) - 128;
        cr = int'({p[14:10], 3'b000}) - 128;
        return {clamp8(y + cr), clamp8(y - cb / 2 - cr / 2), clamp8(y + cb)};
    endfunction

    function automatic logic [14:0] pix(input int unsigned i);
        logic [4:0] a, b, c;
        a = 5'(i * 3);
        b = 5'(31 - i);
        c = 5'(i + 4);
        return {a, b, c};
    endfunction

    // Converter model: conv_ycbcr register is the first stage, one more stage here, packed {R,B,G}.
    logic [14:0] conv_d1 = '0;
    logic [23:0] rgb_d1;
    always @(posedge clk) conv_d1 <= conv_ycbcr;
    assign rgb_d1   = cvt_rgb(conv_d1);
    assign conv_rgb = {rgb_d1[23:16], rgb_d1[7:0], rgb_d1[15:8]};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [25:0] e;
        #2;
        if (!rst) begin
            if (err_line) err_pulses++;
            if (m_valid && m_ready) begin
                out_n++;
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("out_data", m_data, e[23:0]);
                    check("out_sideband", {m_sof, m_eol}, e[25:24]);
                end
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic send(input logic [14:0] d, input logic sof, input logic eol, input logic conv);
        int unsigned w = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_sof   = sof;
        s_eol   = eol;
        while (!s_ready && w < 200) begin
            step();
            w++;
        end
        if (!s_ready) begin
            check("send_timeout", w, 0);
        end else begin
            if (conv) exp_q.push_back({sof, eol, cvt_rgb(d)});
            step();
        end
        s_valid = 1'b0;
        s_sof   = 1'b0;
        s_eol   = 1'b0;
    endtask

    task automatic drain_wait();
        int unsigned w = 0;
        while (exp_q.size() > 0 && w < 300) begin
            step();
            w++;
        end
        check("drain_timeout", exp_q.size(), 0);
    endtask

    task automatic wait_valid(input string tag);
        int unsigned w = 0;
        while (!m_valid && w < 20) begin
            step();
            w++;
        end
        check(tag, m_valid, 1);
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        enable  = 1'b0;
        s_valid = 1'b0;
        step();
        rst = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        int unsigned k;
        int unsigned base;
        repeat (3) step();
        rst = 1'b0;
        check("rst_s_ready", s_ready, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_m_data", m_data, 0);
        check("rst_m_sb", {m_sof, m_eol}, 0);
        check("rst_conv_ycbcr", conv_ycbcr, 0);
        check("rst_err", {15'd0, err_line, err_count}, 0);

        // T1: latency from presentation to first output
        enable  = 1'b1;
        m_ready = 1'b1;
        send(15'h421F, 1'b1, 1'b0, 1'b1);
        k = 1;
        while (!m_valid && k < 20) begin
            step();
            k++;
        end
        check("t1_latency", k, CONV_LAT + 1);
        check("t1_data", m_data, 24'hF8F8F8);
        check("t1_sof", m_sof, 1);
        check("t1_busy", busy, 1);
        drain_wait();

        // T2: non-SOF beats in SYNC are discarded
        do_reset();
        enable  = 1'b1;
        m_ready = 1'b1;
        base    = out_n;
        send(15'h1234, 1'b0, 1'b0, 1'b0);
        send(15'h0ABC, 1'b0, 1'b1, 1'b0);
        send(15'h7FFF, 1'b0, 1'b0, 1'b0);
        send(15'h4210, 1'b1, 1'b0, 1'b1);
        check("t2_conv_ycbcr", conv_ycbcr, 15'h4210);
        wait_valid("t2_valid");
        check("t2_data", m_data, 24'h808080);
        repeat (8) step();
        check("t2_count", out_n - base, 1);

        // T3: backpressure with credit limit
        m_ready = 1'b0;
        base    = out_n;
        for (int unsigned i = 0; i < 4; i++) send(pix(i), 1'b0, 1'b0, 1'b1);
        check("t3_ready_low", s_ready, 0);
        repeat (4) step();
        check("t3_ready_held", s_ready, 0);
        check("t3_none_out", out_n - base, 0);
        check("t3_m_valid", m_valid, 1);
        m_ready = 1'b1;
        for (int unsigned i = 4; i < 20; i++) send(pix(i), 1'b0, (i == 7 || i == 15 || i == 19), 1'b1);
        drain_wait();
        check("t3_count", out_n - base, 20);

        // T4: drain on enable drop
        m_ready = 1'b0;
        base    = out_n;
        for (int unsigned i = 20; i < 23; i++) send(pix(i), 1'b0, 1'b0, 1'b1);
        enable = 1'b0;
        step();
        check("t4_ready_off", s_ready, 0);
        check("t4_busy_draining", busy, 1);
        m_ready = 1'b1;
        k = 0;
        while ((m_valid || exp_q.size() > 0) && k < 50) begin
            step();
            k++;
        end
        check("t4_count", out_n - base, 3);
        step();
        check("t4_busy_off", busy, 0);

        // T5: reset with FIFO full
        enable  = 1'b1;
        m_ready = 1'b0;
        base    = out_n;
        send(pix(30), 1'b1, 1'b0, 1'b1);
        for (int unsigned i = 31; i < 34; i++) send(pix(i), 1'b0, 1'b0, 1'b1);
        repeat (4) step();
        check("t5_full_valid", m_valid, 1);
        check("t5_full_ready", s_ready, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_q.delete();
        check("t5_valid_off", m_valid, 0);
        check("t5_busy_off", busy, 0);
        check("t5_ready_off", s_ready, 0);
        m_ready = 1'b1;
        repeat (10) step();
        check("t5_no_out", out_n - base, 0);

        // T6: lines of 8, 7 and 9 pixels against H_ACTIVE=8
        do_reset();
        enable     = 1'b1;
        m_ready    = 1'b1;
        err_pulses = 0;
        for (int unsigned i = 0; i < 8; i++) send(pix(i), (i == 0), (i == 7), 1'b1);
        for (int unsigned i = 0; i < 7; i++) send(pix(i + 8), 1'b0, (i == 6), 1'b1);
        repeat (2) step();
        check("t6_err_count_mid", err_count, ERR_MID);
        for (int unsigned i = 0; i < 9; i++) send(pix(i + 15), 1'b0, (i == 8), 1'b1);
        drain_wait();
        repeat (3) step();
        check("t6_err_count", err_count, ERR_END);
        check("t6_err_pulses", err_pulses, ERR_END);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
